// File: rtl/tc77_responder.sv
// TC77 temperature-sensor responder: answers the 3-wire SPI read/write
// protocol with a temperature taken from a parallel port, and models the
// conversion period, the first-conversion flag and shutdown mode.
module tc77_responder #(
    parameter logic [15:0] CONV_CYCLES = 16'd1000  // MCLK cycles per conversion, >= 2
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic [12:0] TEMPIN,
    input  logic        nCS,
    input  logic        CLK,
    inout  wire         SIO,
    output logic        SIO_OE,
    output logic        SHUTDOWN,
    output logic        CONVDONE
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_TURN  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // [0],[1] synchronize; [2] holds the previous synchronized value for edge detection
    logic [2:0]  ncs_sync;
    logic [2:0]  clk_sync;
    logic [1:0]  sio_sync;

    logic [2:0]  state;
    logic [15:0] tx_sr;
    logic [15:0] rx_sr;
    logic [4:0]  bit_cnt;
    logic [4:0]  wr_cnt;

    logic [15:0] conv_cnt;
    logic [12:0] temp_reg;

    logic ncs_fall, ncs_rise, clk_fall, clk_rise;
    logic wr_shutdown, wr_run;

    assign ncs_fall = ncs_sync[2] & ~ncs_sync[1];
    assign ncs_rise = ~ncs_sync[2] & ncs_sync[1];
    assign clk_fall = clk_sync[2] & ~clk_sync[1];
    assign clk_rise = ~clk_sync[2] & clk_sync[1];

    // Mode writes take effect only when a complete 16-bit write ends the frame
    assign wr_shutdown = ncs_rise && (state == S_DONE) && (rx_sr == 16'hFFFF);
    assign wr_run      = ncs_rise && (state == S_DONE) && (rx_sr == 16'h0000);

    assign SIO = SIO_OE ? tx_sr[15] : 1'bz;

    // Input synchronizers. nCS resets low so that a chip select already low at
    // reset release is not mistaken for a new falling edge.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            ncs_sync <= '0;
            clk_sync <= '0;
            sio_sync <= '0;
        end else begin
            ncs_sync <= {ncs_sync[1:0], nCS};
            clk_sync <= {clk_sync[1:0], CLK};
            sio_sync <= {sio_sync[0], SIO};
        end
    end

    // Conversion engine and mode register; a 0x0000 write restarts the period
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            conv_cnt <= '0;
            temp_reg <= '0;
            CONVDONE <= 1'b0;
            SHUTDOWN <= 1'b0;
        end else begin
            if (!SHUTDOWN) begin
                if (conv_cnt == CONV_CYCLES - 16'd1) begin
                    conv_cnt <= '0;
                    temp_reg <= TEMPIN;
                    CONVDONE <= 1'b1;
                end else begin
                    conv_cnt <= conv_cnt + 16'd1;
                end
            end else begin
                conv_cnt <= '0;
            end
            if (wr_shutdown) begin
                SHUTDOWN <= 1'b1;
            end else if (wr_run) begin
                SHUTDOWN <= 1'b0;
                conv_cnt <= '0;
                if (SHUTDOWN) CONVDONE <= 1'b0;
            end
        end
    end

    // Serial transaction: 14 bits out, 2 turnaround bits, 16 bits in
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state   <= S_IDLE;
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            wr_cnt  <= '0;
            SIO_OE  <= 1'b0;
        end else if (ncs_rise) begin
            SIO_OE <= 1'b0;
            state  <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ncs_fall) begin
                        tx_sr   <= {temp_reg, CONVDONE, 2'b00};
                        bit_cnt <= '0;
                        SIO_OE  <= 1'b1;
                        state   <= S_READ;
                    end
                end
                S_READ: begin
                    if (clk_fall) begin
                        tx_sr   <= {tx_sr[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd13) begin
                            SIO_OE <= 1'b0;
                            state  <= S_TURN;
                        end
                    end
                end
                S_TURN: begin
                    if (clk_fall) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15) begin
                            wr_cnt <= '0;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (clk_rise) begin
                        rx_sr  <= {rx_sr[14:0], sio_sync[1]};
                        wr_cnt <= wr_cnt + 5'd1;
                        if (wr_cnt == 5'd15) state <= S_DONE;
                    end
                end
                S_DONE: begin
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tc77_responder.sv
// Bench for tc77_responder: a bus-level master drives frames while a
// behavioural model tracks conversions by elapsed-cycle arithmetic.
module tb_tc77_responder;

    localparam int CONV = 400;
    localparam int H    = 5;    // MCLK cycles per serial clock phase

    logic        MCLK = 1'b0;
    logic        nRESET = 1'b1;
    logic        nCS = 1'b1;
    logic        CLK = 1'b0;
    logic        m_oe = 1'b0;
    logic        m_dat = 1'b0;
    logic [12:0] TEMPIN = '0;
    wire         SIO;
    logic        SIO_OE, SHUTDOWN, CONVDONE;

    assign SIO = m_oe ? m_dat : 1'bz;

    always #5 MCLK = ~MCLK;

    tc77_responder #(.CONV_CYCLES(16'd400)) dut (
        .MCLK(MCLK), .nRESET(nRESET), .TEMPIN(TEMPIN), .nCS(nCS), .CLK(CLK),
        .SIO(SIO), .SIO_OE(SIO_OE), .SHUTDOWN(SHUTDOWN), .CONVDONE(CONVDONE)
    );

    int total = 0;
    int bad = 0;
    logic fin = 1'b0;

    // model state: edge count since reset, start of current conversion period
    int          e;
    int          epoch;
    logic        m_sd, m_done;
    logic [12:0] m_temp;
    logic [13:0] m_snap;
    int          snap_at = -1;
    int          wr_at = -1;
    logic [15:0] wr_val = '0;

    // Conversions fall on every CONV-th edge after the period start while
    // running; frame start/end take effect 3 edges after the pin changes.
    always @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            e = 0; epoch = 0; m_sd = 1'b0; m_done = 1'b0; m_temp = '0;
        end else begin
            e = e + 1;
            if (e == snap_at) m_snap = {m_temp, m_done};
            if (!m_sd && e > epoch && ((e - epoch) % CONV) == 0) begin
                m_temp = TEMPIN;
                m_done = 1'b1;
            end
            if (e == wr_at) begin
                if (wr_val == 16'hFFFF) m_sd = 1'b1;
                else if (wr_val == 16'h0000) begin
                    if (m_sd) m_done = 1'b0;
                    m_sd = 1'b0;
                    epoch = e;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int next_conv();
        return epoch + CONV * ((e - epoch) / CONV + 1);
    endfunction

    // One frame; call at a negedge. nrd clocks of read/turnaround, then nwr write clocks.
    task automatic xact(input int nrd, input int nwr, input logic [15:0] wd,
                        output logic [13:0] rw);
        rw = '0;
        nCS = 1'b0;
        snap_at = e + 3;
        repeat (H) @(negedge MCLK);
        for (int b = 1; b <= nrd; b++) begin
            CLK = 1'b1;
            if (b <= 14) rw = {rw[12:0], SIO};
            check("oe_read_phase", 32'(SIO_OE), (b <= 14) ? 32'd1 : 32'd0);
            repeat (H) @(negedge MCLK);
            CLK = 1'b0;
            repeat (H) @(negedge MCLK);
        end
        for (int b = 0; b < nwr; b++) begin
            m_oe = 1'b1;
            m_dat = wd[15-b];
            repeat (H) @(negedge MCLK);
            CLK = 1'b1;
            check("oe_write_phase", 32'(SIO_OE), 32'd0);
            repeat (H) @(negedge MCLK);
            CLK = 1'b0;
        end
        if (nwr > 0) repeat (H) @(negedge MCLK);
        m_oe = 1'b0;
        if (nrd > 0 && nrd < 14) check("oe_before_abort", 32'(SIO_OE), 32'd1);
        if (nrd == 16 && nwr == 16) begin
            wr_val = wd;
            wr_at = e + 3;
        end
        nCS = 1'b1;
        repeat (3) @(negedge MCLK);
        check("oe_after_ncs_high", 32'(SIO_OE), 32'd0);
        repeat (4) @(negedge MCLK);
    endtask

    initial begin
        fork
            // compare process: mode outputs against the model every cycle
            begin
                while (!fin) begin
                    @(negedge MCLK);
                    check("shutdown_vs_model", 32'(SHUTDOWN), 32'(m_sd));
                    check("convdone_vs_model", 32'(CONVDONE), 32'(m_done));
                end
            end
            begin : main
                logic [13:0] rw;
                int t, w0, n, nrd, nwr, kind;
                logic [15:0] wd;

                #2 nRESET = 1'b0;
                repeat (3) @(negedge MCLK);
                check("reset_oe", 32'(SIO_OE), 32'd0);
                check("reset_sd", 32'(SHUTDOWN), 32'd0);
                check("reset_done", 32'(CONVDONE), 32'd0);
                @(posedge MCLK); #2 nRESET = 1'b1;
                @(negedge MCLK);

                // read before any conversion
                while (e < 100) @(negedge MCLK);
                xact(16, 0, 16'h0, rw);
                check("rd_before_conv", 32'(rw), 32'h0000);
                check("rd_before_conv_model", 32'(rw), 32'(m_snap));

                // first conversion lands exactly CONV edges after reset release
                TEMPIN = 13'h01C0;
                t = 0;
                while (!CONVDONE && t < 2 * CONV) begin @(negedge MCLK); t++; end
                check("first_convdone_edge", 32'(e), 32'(CONV));
                repeat (10) @(negedge MCLK);
                xact(16, 0, 16'h0, rw);
                check("rd_28C", 32'(rw), 32'h0381);
                check("rd_28C_model", 32'(rw), 32'(m_snap));

                // negative temperature
                TEMPIN = 13'h1F60;
                n = next_conv() + 5;
                while (e < n) @(negedge MCLK);
                xact(16, 0, 16'h0, rw);
                check("rd_neg10C", 32'(rw), 32'h3EC1);

                // shutdown freezes the reading
                xact(16, 16, 16'hFFFF, rw);
                check("sd_set", 32'(SHUTDOWN), 32'd1);
                TEMPIN = 13'h0AAA;
                repeat (CONV + 10) @(negedge MCLK);
                xact(16, 0, 16'h0, rw);
                check("rd_frozen", 32'(rw), 32'h3EC1);

                // leave shutdown: flag clears, returns after CONV edges
                xact(16, 16, 16'h0000, rw);
                w0 = wr_at;
                check("sd_clear", 32'(SHUTDOWN), 32'd0);
                check("done_clear", 32'(CONVDONE), 32'd0);
                t = 0;
                while (!CONVDONE && t < 2 * CONV) begin @(negedge MCLK); t++; end
                check("restart_convdone_edge", 32'(e - w0), 32'(CONV));
                xact(16, 0, 16'h0, rw);
                check("rd_after_restart", 32'(rw), 32'h1555);

                // abort during read, partial write of ones
                xact(7, 0, 16'h0, rw);
                xact(16, 9, 16'hFFFF, rw);
                check("partial_write_sd", 32'(SHUTDOWN), 32'd0);

                // conversion completes while bit 5 is on the wire
                n = next_conv();
                if (n - e < 60) n = n + CONV;
                while (e < n - 50) @(negedge MCLK);
                TEMPIN = 13'h0123;
                xact(16, 0, 16'h0, rw);
                check("snap_mid_old", 32'(rw), 32'h1555);
                xact(16, 0, 16'h0, rw);
                check("snap_mid_new", 32'(rw), 32'h0247);

                // conversion on the very edge the frame starts
                n = next_conv();
                if (n - e < 10) n = n + CONV;
                while (e < n - 3) @(negedge MCLK);
                TEMPIN = 13'h1000;
                xact(16, 0, 16'h0, rw);
                check("snap_same_edge", 32'(rw), 32'h0247);
                check("snap_same_edge_model", 32'(rw), 32'(m_snap));
                xact(16, 0, 16'h0, rw);
                check("snap_same_edge_next", 32'(rw), 32'h2001);

                // randomized frames and temperature changes
                for (int i = 0; i < 25; i++) begin
                    kind = int'($urandom_range(0, 5));
                    nrd = 16; nwr = 0;
                    wd = 16'($urandom);
                    if (kind == 2 || kind == 3) begin
                        nwr = 16;
                        wd = (kind == 2) ? 16'h0000 : (($urandom_range(0, 1) == 0) ? 16'hFFFF : wd);
                    end else if (kind == 4) begin
                        nrd = int'($urandom_range(1, 15));
                    end else if (kind == 5) begin
                        nwr = int'($urandom_range(1, 15));
                    end
                    repeat ($urandom_range(0, 600)) @(negedge MCLK);
                    fork
                        xact(nrd, nwr, wd, rw);
                        begin
                            repeat ($urandom_range(1, 350)) @(negedge MCLK);
                            TEMPIN = 13'($urandom);
                        end
                    join
                    if (nrd == 16) check("rand_read_model", 32'(rw), 32'(m_snap));
                end

                // reset in the middle of a read with nCS held low
                snap_at = -1;
                wr_at = -1;
                nCS = 1'b0;
                repeat (20) @(negedge MCLK);
                check("oe_mid_read", 32'(SIO_OE), 32'd1);
                @(posedge MCLK); #2 nRESET = 1'b0;
                #1 check("oe_async_release", 32'(SIO_OE), 32'd0);
                repeat (3) @(negedge MCLK);
                @(posedge MCLK); #2 nRESET = 1'b1;
                repeat (20) @(negedge MCLK);
                check("oe_stays_idle_ncs_low", 32'(SIO_OE), 32'd0);
                nCS = 1'b1;
                repeat (10) @(negedge MCLK);
                xact(16, 0, 16'h0, rw);
                check("rd_after_reset", 32'(rw), 32'h0000);
                check("rd_after_reset_model", 32'(rw), 32'(m_snap));

                fin = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tc77_responder.md
# tc77_responder

Behavioural-synthesizable TC77 SPI temperature-sensor responder. It answers the 3-wire TC77 read/write protocol issued by the board's temperature loader, so the startup-delay and fan-control logic can be exercised on the bench and in FPGA loop-back without a physical sensor. The temperature value comes from a parallel input port. The block models conversion timing, the first-conversion-complete flag, and shutdown/continuous mode writes.

## Interface
- CONV_CYCLES, 16'd1000: MCLK cycles per temperature conversion. Must be ≥ 2.
- MCLK  in  1  system clock; the only clock.
- nRESET  in  1  asynchronous, active-low reset.
- TEMPIN  in  13  two's-complement temperature, 0.0625 °C/LSB.
- nCS  in  1  chip select from the master, asynchronous to MCLK.
- CLK  in  1  serial clock from the master, asynchronous to MCLK, idles low.
- SIO  inout  1  serial data; driven only while SIO_OE = 1, otherwise 1'bz.
- SIO_OE  out  1  responder is driving SIO.
- SHUTDOWN  out  1  shutdown mode active.
- CONVDONE  out  1  at least one conversion has completed since reset or since leaving shutdown.

## Operation
- nCS, CLK and SIO input each pass through a 2-flop synchronizer. Edges are detected on the synchronized nCS and CLK.
- Conversion engine:
  - The counter runs while SHUTDOWN = 0. At count CONV_CYCLES-1 it latches TEMPIN into temp_reg[12:0], sets CONVDONE = 1, and wraps to 0.
  - While SHUTDOWN = 1 the counter holds at 0. temp_reg and CONVDONE hold.
- Transaction state machine has states IDLE, READ, TURN, WRITE, DONE.
  - IDLE: on nCS falling, snapshot tx_sr = {temp_reg, CONVDONE, 2'b00}, set bit_cnt = 0, SIO_OE = 1, SIO = tx_sr[15], go to READ.
  - READ: on each CLK falling edge, shift tx_sr left and increment bit_cnt. When bit_cnt reaches 14, set SIO_OE = 0 and go to TURN. The master therefore sees 13 temperature bits, then the flag bit, on rising edges 1..14.
  - TURN: hi-Z for bits 14 and 15. After the CLK falling edge that ends bit 15 (bit_cnt = 16), go to WRITE.
  - WRITE: on each CLK rising edge, shift synchronized SIO into rx_sr[15:0] and increment wr_cnt. At wr_cnt = 16 go to DONE.
  - DONE: ignore further clocks.
- nCS rising (any state): SIO_OE = 0 and return to IDLE.
  - If the state was DONE: rx_sr = 16'hFFFF sets SHUTDOWN = 1. rx_sr = 16'h0000 clears SHUTDOWN and restarts the conversion counter at 0. Leaving shutdown this way clears CONVDONE. Any other value is ignored.
  - A partial write, or an abort during READ or TURN, changes no mode state.
- Snapshot rule: a conversion completing mid-transaction updates temp_reg and CONVDONE but not tx_sr. The new value appears on the next transaction.
- Reset values: SIO_OE = 0, SHUTDOWN = 0, CONVDONE = 0, temp_reg = 0, state = IDLE, all counters 0.

## Timing
- Pin edge to synchronized edge pulse: 2 MCLK.
- SIO update after a CLK falling pin edge: ≤ 3 MCLK.
- After nCS falling, SIO drives the MSB within 3 MCLK.
- Master constraints: CLK high and low times ≥ 4 MCLK each. First CLK rising edge ≥ 4 MCLK after nCS falling.
- First CONVDONE assertion occurs exactly CONV_CYCLES MCLK after nRESET deasserts, or after the 0x0000 write takes effect.
- Simultaneous conversion-complete and nCS falling in the same MCLK: the snapshot takes the pre-update temp_reg and CONVDONE.
- Asynchronous reset mid-transaction: SIO released immediately. The block returns to IDLE and waits for the next nCS falling edge, even if nCS is already low at reset release.

## Test plan
- Read before the first conversion: nCS falls 100 MCLK after reset, 16 clocks → master receives 14-bit {13'h0000, 1'b0}; SIO hi-Z from bit 14.
- Read after a conversion: TEMPIN = 13'h01C0, wait CONV_CYCLES+10 → master's 14-bit word is 14'h0381, i.e. the top 13 bits are 13'h01C0 (28.0 °C) and bit 0 = 1.
- Negative temperature: TEMPIN = 13'h1F60 (−10 °C), read → 14-bit word 14'h3EC1; sign bit = 1.
- Shutdown write: 16 read clocks, then 16 write clocks of 0xFFFF, nCS high → SHUTDOWN = 1. A later TEMPIN change does not change the read value. Writing 0x0000 → SHUTDOWN = 0 and CONVDONE = 0, which returns to 1 after CONV_CYCLES.
- Abort and partial write: nCS high after 7 read clocks → SIO_OE = 0 within 3 MCLK. 16 read clocks plus 9 write clocks of 1s → SHUTDOWN stays 0.
- Snapshot: conversion completes while bit 5 is being shifted → the current word is unchanged, and the next read returns the new TEMPIN.
